tcdm_rr_arbiter: RTL and testbench
==================================

Name: tcdm_rr_arbiter

Overview:
- Shares one TCDM slave port between NR_INPUTS TCDM master ports using round-robin arbitration.
- Allows at most one outstanding transaction on the slave side.
- Routes each response back to the master whose request was granted.
- It is the N:1 counterpart of the SoC TCDM demultiplexer and sits in front of single-ported peripherals and memory banks in the SoC interconnect.

Parameters:
- NR_INPUTS, 2, number of master ports; legal values are ≥1.
- SEL_WIDTH (localparam), max(1, $clog2(NR_INPUTS)), width of the owner register and the round-robin pointer.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- in_req_i  in  NR_INPUTS  per-master request
- in_add_i  in  NR_INPUTS x 32  per-master byte address
- in_wen_i  in  NR_INPUTS  per-master write enable, active low (1 = read)
- in_wdata_i  in  NR_INPUTS x 32  per-master write data
- in_be_i  in  NR_INPUTS x 4  per-master byte enables
- in_gnt_o  out  NR_INPUTS  per-master grant
- in_r_valid_o  out  NR_INPUTS  per-master response valid
- in_r_rdata_o  out  32  response data, broadcast to all masters
- in_r_opc_o  out  1  response error flag, broadcast to all masters
- out_req_o  out  1  slave request
- out_add_o  out  32  slave address
- out_wen_o  out  1  slave write enable, active low
- out_wdata_o  out  32  slave write data
- out_be_o  out  4  slave byte enables
- out_gnt_i  in  1  slave grant
- out_r_valid_i  in  1  slave response valid
- out_r_rdata_i  in  32  slave response data
- out_r_opc_i  in  1  slave response error
- busy_o  out  1  high while a transaction is outstanding (state_q == PENDING)

Behaviour:
- Registers are state_q (IDLE/PENDING), owner_q and rr_q. All reset asynchronously to IDLE, 0 and 0.
- Selection (combinational):
  - sel = first index i with in_req_i[i]=1, scanning rr_q, rr_q+1, … modulo NR_INPUTS.
  - any_req = |in_req_i.
- Issue window: open = (state_q==IDLE) || (state_q==PENDING && out_r_valid_i).
- Request path:
  - When open && any_req: out_req_o=1 and out_add/wen/wdata/be come from master sel.
  - Otherwise: out_req_o=0, out_add_o='0, out_wdata_o='0, out_be_o='0, out_wen_o=1.
- Grant:
  - in_gnt_o[sel] = open && any_req && out_gnt_i. All other grants are 0. At most one in_gnt_o bit is high per cycle.
  - On grant: owner_q<=sel, rr_q<=(sel+1) mod NR_INPUTS, state_d=PENDING.
- Response:
  - In PENDING: in_r_valid_o[owner_q]=out_r_valid_i. in_r_rdata_o/in_r_opc_o pass out_r_rdata_i/out_r_opc_i through unregistered.
  - In IDLE: all in_r_valid_o=0 and in_r_rdata_o='0, in_r_opc_o=0. A spurious out_r_valid_i in IDLE is dropped.
- FSM transitions:
  - IDLE → PENDING on a grant; otherwise stay in IDLE.
  - PENDING with out_r_valid_i=0 stays in PENDING; no request is issued.
  - PENDING with out_r_valid_i=1 and a grant in the same cycle (back-to-back) stays in PENDING with the new owner. The old owner still receives r_valid in that cycle.
  - PENDING with out_r_valid_i=1 and no grant goes to IDLE.
- Latency: zero-cycle combinational request and grant path. The response reaches the master in the same cycle as out_r_valid_i. Best-case throughput is 1 transaction per cycle when the slave answers in the cycle after its grant.
- Fairness:
  - rr_q changes only on a grant.
  - A requesting master is granted within NR_INPUTS grants.
  - The selected master may change between ungranted cycles if a higher-priority master raises req. This is legal under TCDM because masters hold req until gnt.
- NR_INPUTS=1: sel is always 0 and rr_q stays 0.
- Reset mid-transaction: returns to IDLE and abandons any outstanding response. No in_r_valid_o may assert until a new grant.

Test Plan:
- NR_INPUTS=4, only master 2 reads addr 0x1A10_0000, slave gnt same cycle, r_valid next cycle with rdata 0xDEAD_BEEF → in_gnt_o=4'b0100 in cycle 0; in_r_valid_o=4'b0100 and in_r_rdata_o=0xDEAD_BEEF in cycle 1; then IDLE and busy_o=0.
- All 4 masters request continuously, slave always grants, single-cycle responses → grant order 0,1,2,3,0,… with one grant per cycle. Each r_valid goes to the previous cycle's owner.
- Slave withholds gnt for 3 cycles while master 1 holds a write (be=4'hF) → out_req_o=1 for all 3 cycles with stable master-1 fields; in_gnt_o=0 until out_gnt_i=1.
- Slave response delayed 5 cycles after grant while masters 0 and 3 request → out_req_o=0 and busy_o=1 during the wait. The next grant coincides with out_r_valid_i.
- out_r_valid_i pulsed in IDLE with no grant → all in_r_valid_o remain 0.
- rst_ni asserted while PENDING with owner 3 → state IDLE, rr_q=0, busy_o=0 immediately; a late out_r_valid_i after reset release is dropped.

Source files
------------

// File: rtl/tcdm_rr_arbiter.sv
// N:1 round-robin arbiter sharing one TCDM slave port between NR_INPUTS masters.
// At most one outstanding transaction; responses are routed back to the granted master.
module tcdm_rr_arbiter #(
  parameter int NR_INPUTS = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NR_INPUTS-1:0]        in_req_i,
  input  logic [NR_INPUTS-1:0][31:0]  in_add_i,
  input  logic [NR_INPUTS-1:0]        in_wen_i,
  input  logic [NR_INPUTS-1:0][31:0]  in_wdata_i,
  input  logic [NR_INPUTS-1:0][3:0]   in_be_i,
  output logic [NR_INPUTS-1:0]        in_gnt_o,
  output logic [NR_INPUTS-1:0]        in_r_valid_o,
  output logic [31:0]                 in_r_rdata_o,
  output logic                        in_r_opc_o,
  output logic                        out_req_o,
  output logic [31:0]                 out_add_o,
  output logic                        out_wen_o,
  output logic [31:0]                 out_wdata_o,
  output logic [3:0]                  out_be_o,
  input  logic                        out_gnt_i,
  input  logic                        out_r_valid_i,
  input  logic [31:0]                 out_r_rdata_i,
  input  logic                        out_r_opc_i,
  output logic                        busy_o
);

  localparam int SEL_WIDTH = (NR_INPUTS > 1) ? $clog2(NR_INPUTS) : 1;
  localparam int unsigned NR_U = NR_INPUTS;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  state_e                 r_state;
  state_e                 w_state_d;
  logic [SEL_WIDTH-1:0]   r_owner;
  logic [SEL_WIDTH-1:0]   r_rr;

  logic [SEL_WIDTH-1:0]   w_sel;
  logic                   w_any;
  logic                   w_open;
  logic                   w_grant;
  int unsigned            w_dist;
  int unsigned            w_best;

  // Pick the requester with the smallest rotated distance from the pointer.
  always_comb begin
    w_any  = |in_req_i;
    w_sel  = '0;
    w_best = NR_U;
    w_dist = 0;
    for (int unsigned i = 0; i < NR_U; i++) begin
      w_dist = (i + NR_U - 32'(r_rr)) % NR_U;
      if (in_req_i[SEL_WIDTH'(i)] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_sel  = SEL_WIDTH'(i);
      end
    end
  end

  assign w_open  = (r_state == IDLE) || out_r_valid_i;
  assign w_grant = w_open && w_any && out_gnt_i;
  assign busy_o  = (r_state == PENDING);

  always_comb begin
    out_req_o   = 1'b0;
    out_add_o   = '0;
    out_wen_o   = 1'b1;
    out_wdata_o = '0;
    out_be_o    = '0;
    in_gnt_o    = '0;
    if (w_open && w_any) begin
      out_req_o   = 1'b1;
      out_add_o   = in_add_i[w_sel];
      out_wen_o   = in_wen_i[w_sel];
      out_wdata_o = in_wdata_i[w_sel];
      out_be_o    = in_be_i[w_sel];
    end
    if (w_grant) begin
      in_gnt_o[w_sel] = 1'b1;
    end
  end

  // Response path is unregistered; a response seen while IDLE is discarded.
  always_comb begin
    in_r_valid_o = '0;
    in_r_rdata_o = '0;
    in_r_opc_o   = 1'b0;
    if (r_state == PENDING) begin
      in_r_valid_o[r_owner] = out_r_valid_i;
      in_r_rdata_o          = out_r_rdata_i;
      in_r_opc_o            = out_r_opc_i;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_d = PENDING;
      PENDING: if (out_r_valid_i && !w_grant) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_grant) begin
        r_owner <= w_sel;
        r_rr    <= SEL_WIDTH'((32'(w_sel) + 1) % NR_U);
      end
    end
  end

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Self-checking bench for tcdm_rr_arbiter (NR_INPUTS=4): directed scenarios
// with literal expectations plus randomized traffic against a behavioural model.
module tb_tcdm_rr_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      in_req = '0;
  logic [N-1:0][31:0] in_add = '0;
  logic [N-1:0]      in_wen = '1;
  logic [N-1:0][31:0] in_wdata = '0;
  logic [N-1:0][3:0] in_be = '0;
  logic [N-1:0]      in_gnt;
  logic [N-1:0]      in_r_valid;
  logic [31:0]       in_r_rdata;
  logic              in_r_opc;
  logic              out_req;
  logic [31:0]       out_add;
  logic              out_wen;
  logic [31:0]       out_wdata;
  logic [3:0]        out_be;
  logic              out_gnt = 1'b0;
  logic              out_r_valid = 1'b0;
  logic [31:0]       out_r_rdata = '0;
  logic              out_r_opc = 1'b0;
  logic              busy;

  always #5 clk = ~clk;

  tcdm_rr_arbiter #(.NR_INPUTS(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_req_i(in_req), .in_add_i(in_add), .in_wen_i(in_wen),
    .in_wdata_i(in_wdata), .in_be_i(in_be),
    .in_gnt_o(in_gnt), .in_r_valid_o(in_r_valid),
    .in_r_rdata_o(in_r_rdata), .in_r_opc_o(in_r_opc),
    .out_req_o(out_req), .out_add_o(out_add), .out_wen_o(out_wen),
    .out_wdata_o(out_wdata), .out_be_o(out_be),
    .out_gnt_i(out_gnt), .out_r_valid_i(out_r_valid),
    .out_r_rdata_i(out_r_rdata), .out_r_opc_i(out_r_opc),
    .busy_o(busy)
  );

  int checks = 0;
  int failures = 0;

  // Model state: is a transaction outstanding, who owns it, who is first in line.
  bit m_pend = 0;
  int m_owner = 0;
  int m_rr = 0;
  bit n_pend;
  int n_owner;
  int n_rr;
  logic [N-1:0] e_gnt = '0;
  int wait_cnt [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int rr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (((req >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (((v >> i) & 4'd1) != 4'd0) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = 0;
    m_owner = 0;
    m_rr = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic eval_cycle();
    int sel;
    bit any, open, grant_now, req_now;
    logic [N-1:0] e_rv;
    logic [31:0] sel_bits;
    #3;
    sel = pick(in_req, m_rr);
    any = (in_req != '0);
    open = !m_pend || out_r_valid;
    req_now = open && any;
    grant_now = req_now && out_gnt;
    sel_bits = 32'(sel);
    e_gnt = grant_now ? (4'd1 << sel_bits[1:0]) : 4'd0;
    e_rv = (m_pend && out_r_valid) ? (4'd1 << m_owner) : 4'd0;
    chk("gnt", 64'(in_gnt), 64'(e_gnt));
    chk("r_valid", 64'(in_r_valid), 64'(e_rv));
    chk("r_rdata", 64'(in_r_rdata), m_pend ? 64'(out_r_rdata) : 64'd0);
    chk("r_opc", 64'(in_r_opc), m_pend ? 64'(out_r_opc) : 64'd0);
    chk("busy", 64'(busy), 64'(m_pend));
    chk("out_req", 64'(out_req), 64'(req_now));
    chk("out_add", 64'(out_add), req_now ? 64'(in_add[sel_bits[1:0]]) : 64'd0);
    chk("out_wen", 64'(out_wen), req_now ? 64'(in_wen[sel_bits[1:0]]) : 64'd1);
    chk("out_wdata", 64'(out_wdata), req_now ? 64'(in_wdata[sel_bits[1:0]]) : 64'd0);
    chk("out_be", 64'(out_be), req_now ? 64'(in_be[sel_bits[1:0]]) : 64'd0);
    if (in_gnt != '0) begin
      for (int i = 0; i < N; i++) begin
        if (((in_req >> i) & 4'd1) == 4'd0) wait_cnt[i] = 0;
        else if (((in_gnt >> i) & 4'd1) != 4'd0) begin
          chk("fair_wait", 64'(wait_cnt[i] < N), 64'd1);
          wait_cnt[i] = 0;
        end else wait_cnt[i]++;
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (((in_req >> i) & 4'd1) == 4'd0) wait_cnt[i] = 0;
    end
    n_pend = m_pend;
    n_owner = m_owner;
    n_rr = m_rr;
    if (grant_now) begin
      n_pend = 1;
      n_owner = sel;
      n_rr = (sel + 1) % N;
    end else if (m_pend && out_r_valid) begin
      n_pend = 0;
    end
  endtask

  task automatic adv();
    if (rst_n) begin
      m_pend = n_pend;
      m_owner = n_owner;
      m_rr = n_rr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_req = '0;
    out_gnt = 1'b0;
    out_r_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    eval_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    do_reset();
    chk("reset_busy", 64'(busy), 64'd0);

    // Single read from master 2.
    in_req = 4'b0100;
    in_add[2] = 32'h1A10_0000;
    in_wen[2] = 1'b1;
    out_gnt = 1'b1;
    eval_cycle();
    chk("t1_gnt", 64'(in_gnt), 64'h4);
    chk("t1_add", 64'(out_add), 64'h1A10_0000);
    adv();
    in_req = '0;
    out_gnt = 1'b0;
    out_r_valid = 1'b1;
    out_r_rdata = 32'hDEAD_BEEF;
    eval_cycle();
    chk("t1_rvalid", 64'(in_r_valid), 64'h4);
    chk("t1_rdata", 64'(in_r_rdata), 64'hDEAD_BEEF);
    adv();
    out_r_valid = 1'b0;
    eval_cycle();
    chk("t1_idle_busy", 64'(busy), 64'd0);
    adv();

    // Continuous requests from all masters, slave answers next cycle.
    do_reset();
    in_req = 4'b1111;
    out_gnt = 1'b1;
    for (int c = 0; c < 8; c++) begin
      out_r_valid = m_pend;
      out_r_rdata = $urandom;
      eval_cycle();
      chk("t2_order", 64'(onehot_idx(in_gnt)), 64'(order[c]));
      if (c > 0) chk("t2_rv_prev", 64'(in_r_valid), 64'(4'd1 << order[c-1]));
      adv();
    end
    in_req = '0;
    out_gnt = 1'b0;
    out_r_valid = 1'b1;
    eval_cycle();
    adv();

    // Slave stalls grant while master 1 holds a write.
    out_r_valid = 1'b0;
    in_req = 4'b0010;
    in_add[1] = 32'h0000_1234;
    in_wen[1] = 1'b0;
    in_wdata[1] = 32'hCAFE_F00D;
    in_be[1] = 4'hF;
    for (int c = 0; c < 3; c++) begin
      eval_cycle();
      chk("t3_req", 64'(out_req), 64'd1);
      chk("t3_add", 64'(out_add), 64'h1234);
      chk("t3_wen", 64'(out_wen), 64'd0);
      chk("t3_wdata", 64'(out_wdata), 64'hCAFE_F00D);
      chk("t3_gnt0", 64'(in_gnt), 64'd0);
      adv();
    end
    out_gnt = 1'b1;
    eval_cycle();
    chk("t3_gnt", 64'(in_gnt), 64'h2);
    adv();

    // Slow response while masters 0 and 3 wait.
    in_req = 4'b1001;
    in_wen[0] = 1'b1;
    in_wen[3] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      eval_cycle();
      chk("t4_noreq", 64'(out_req), 64'd0);
      chk("t4_busy", 64'(busy), 64'd1);
      adv();
    end
    out_r_valid = 1'b1;
    eval_cycle();
    chk("t4_b2b_gnt", 64'(in_gnt), 64'h8);
    chk("t4_b2b_rv", 64'(in_r_valid), 64'h2);
    adv();
    in_req = 4'b0001;
    eval_cycle();
    chk("t4_next_gnt", 64'(in_gnt), 64'h1);
    chk("t4_next_rv", 64'(in_r_valid), 64'h8);
    adv();
    in_req = '0;
    eval_cycle();
    adv();

    // Spurious response while idle.
    out_gnt = 1'b0;
    eval_cycle();
    chk("t5_spurious", 64'(in_r_valid), 64'd0);
    adv();

    // Reset while master 3 owns a transaction.
    out_r_valid = 1'b0;
    out_gnt = 1'b1;
    in_req = 4'b1000;
    eval_cycle();
    chk("t6_gnt3", 64'(in_gnt), 64'h8);
    adv();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_busy", 64'(busy), 64'd0);
    out_r_valid = 1'b1;
    eval_cycle();
    chk("t6_rst_rv", 64'(in_r_valid), 64'd0);
    adv();
    rst_n = 1'b1;
    eval_cycle();
    chk("t6_late_rv", 64'(in_r_valid), 64'd0);
    adv();
    out_r_valid = 1'b0;
    in_req = 4'b1111;
    out_gnt = 1'b1;
    eval_cycle();
    chk("t6_rr0", 64'(in_gnt), 64'h1);
    adv();

    // Randomized traffic; masters hold their request until granted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_req[i] || e_gnt[i]) begin
          in_req[i] = ($urandom_range(1, 0) == 1);
          in_add[i] = $urandom;
          in_wen[i] = $urandom_range(1, 0) == 1;
          in_wdata[i] = $urandom;
          in_be[i] = 4'($urandom_range(15, 0));
        end
      end
      out_gnt = ($urandom_range(9, 0) < 6);
      out_r_valid = m_pend ? ($urandom_range(9, 0) < 4) : ($urandom_range(19, 0) == 0);
      out_r_rdata = $urandom;
      out_r_opc = $urandom_range(1, 0) == 1;
      eval_cycle();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
